// File: rtl/zbuf_depth_test.sv
// Per-fragment depth test in front of zbuf_cache: read stored z, compare, write back on pass, emit pixel.
// Latency: accept->compare is 3 cycles on a cache hit; a pass adds UPDATE and EMIT, so hits take >= 4 cycles per fragment.
// Backpressure: one fragment in flight; frag_ready only in IDLE; waits indefinitely on zc_hit, zc_upd_hit and pix_ready.
module zbuf_depth_test #(
  parameter int NUM_X_BLOCKS = 160,
  parameter int X_W          = 10,
  parameter int Y_W          = 10,
  parameter int COLOR_W      = 16,
  parameter int DEPTH_FUNC   = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               frag_valid,
  output logic               frag_ready,
  input  logic [X_W-1:0]     frag_x,
  input  logic [Y_W-1:0]     frag_y,
  input  logic [15:0]        frag_z,
  input  logic [COLOR_W-1:0] frag_color,
  output logic [18:0]        zc_frag_id,
  output logic               zc_rd_en,
  input  logic               zc_hit,
  input  logic [15:0]        zc_zval,
  output logic [18:0]        zc_upd_id,
  output logic               zc_upd_en,
  output logic [15:0]        zc_upd_val,
  input  logic               zc_upd_hit,
  output logic               pix_valid,
  input  logic               pix_ready,
  output logic [X_W-1:0]     pix_x,
  output logic [Y_W-1:0]     pix_y,
  output logic [COLOR_W-1:0] pix_color,
  input  logic               cnt_clr,
  output logic [15:0]        pass_cnt,
  output logic [15:0]        cull_cnt
);

  // Fragment held for the whole lifetime of one depth test.
  typedef struct packed {
    logic [X_W-1:0]     x;
    logic [Y_W-1:0]     y;
    logic [15:0]        z;
    logic [COLOR_W-1:0] color;
  } frag_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_CAPTURE,
    S_COMPARE,
    S_UPDATE,
    S_EMIT
  } state_t;

  state_t      state;
  state_t      state_nxt;
  frag_t       frag_q;
  logic [15:0] zval_q;
  logic [14:0] blk_id;
  logic [18:0] frag_id;
  logic        frag_acc;
  logic        z_pass;

  // Block index wraps to the cache's 15-bit block field; the 4-bit sub index is the
  // position inside the 4x4 block, row-major.
  assign blk_id  = 15'(32'(frag_q.y >> 2) * 32'(NUM_X_BLOCKS) + 32'(frag_q.x >> 2));
  assign frag_id = {blk_id, frag_q.y[1:0], frag_q.x[1:0]};

  assign frag_acc = frag_valid & frag_ready;

  // Depth compare is unsigned; LEQUAL lets an equal-depth fragment overwrite.
  assign z_pass = (DEPTH_FUNC != 0) ? (frag_q.z <= zval_q) : (frag_q.z < zval_q);

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state: every wait on the cache or downstream is unbounded by design.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (frag_valid)  state_nxt = S_LOOKUP;
      S_LOOKUP:  if (zc_hit)      state_nxt = S_CAPTURE;
      S_CAPTURE:                  state_nxt = S_COMPARE;
      S_COMPARE:                  state_nxt = z_pass ? S_UPDATE : S_IDLE;
      S_UPDATE:  if (zc_upd_hit)  state_nxt = S_EMIT;
      S_EMIT:    if (pix_ready)   state_nxt = S_IDLE;
      default:                    state_nxt = S_IDLE;
    endcase
  end

  // Control outputs decoded from state; read and update enables are in disjoint states.
  always_comb begin
    frag_ready = 1'b0;
    zc_rd_en   = 1'b0;
    zc_upd_en  = 1'b0;
    pix_valid  = 1'b0;
    case (state)
      S_IDLE:    frag_ready = 1'b1;
      S_LOOKUP:  zc_rd_en   = 1'b1;
      S_CAPTURE: zc_rd_en   = 1'b1;
      S_UPDATE:  zc_upd_en  = 1'b1;
      S_EMIT:    pix_valid  = 1'b1;
      default:   frag_ready = 1'b0;
    endcase
  end

  // Latch the fragment on accept; it stays put until the next accept.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frag_q <= '0;
    end else if (frag_acc) begin
      frag_q <= '{x: frag_x, y: frag_y, z: frag_z, color: frag_color};
    end
  end

  // The BRAM data is valid the cycle after the hit, so capture it in CAPTURE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      zval_q <= '0;
    end else if (state == S_CAPTURE) begin
      zval_q <= zc_zval;
    end
  end

  // Pass counter: counts on the update write cycle; clear takes priority.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pass_cnt <= '0;
    end else if (cnt_clr) begin
      pass_cnt <= '0;
    end else if ((state == S_UPDATE) && zc_upd_hit) begin
      pass_cnt <= pass_cnt + 16'd1;
    end
  end

  // Cull counter: counts on a failed compare; clear takes priority.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cull_cnt <= '0;
    end else if (cnt_clr) begin
      cull_cnt <= '0;
    end else if ((state == S_COMPARE) && !z_pass) begin
      cull_cnt <= cull_cnt + 16'd1;
    end
  end

  // Address and data outputs come straight from the held fragment, so they are
  // stable for the whole lookup, update and emit phases.
  assign zc_frag_id = frag_id;
  assign zc_upd_id  = frag_id;
  assign zc_upd_val = frag_q.z;
  assign pix_x      = frag_q.x;
  assign pix_y      = frag_q.y;
  assign pix_color  = frag_q.color;

endmodule

// File: tb/tb_zbuf_depth_test.sv
module tb_zbuf_depth_test;
  localparam int NXB = 160;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // Main DUT (LESS)
  logic        frag_valid = 1'b0, frag_ready;
  logic [9:0]  frag_x = '0, frag_y = '0;
  logic [15:0] frag_z = '0, frag_color = '0;
  logic [18:0] zc_frag_id, zc_upd_id;
  logic        zc_rd_en, zc_hit, zc_upd_en, zc_upd_hit;
  logic [15:0] zc_zval, zc_upd_val;
  logic        pix_valid, pix_ready;
  logic [9:0]  pix_x, pix_y;
  logic [15:0] pix_color;
  logic        cnt_clr = 1'b0;
  logic [15:0] pass_cnt, cull_cnt;

  // Second DUT (LEQUAL) against an always-hitting cache holding 0x2000
  logic        l_frag_valid = 1'b0, l_frag_ready;
  logic [9:0]  l_frag_x = '0, l_frag_y = '0;
  logic [15:0] l_frag_z = '0;
  logic [18:0] l_zc_frag_id, l_zc_upd_id;
  logic        l_zc_rd_en, l_zc_upd_en, l_pix_valid;
  logic [15:0] l_zc_upd_val, l_pix_color, l_pass_cnt, l_cull_cnt;
  logic [9:0]  l_pix_x, l_pix_y;

  zbuf_depth_test #(.DEPTH_FUNC(0)) u_dut (
    .clk(clk), .rst(rst),
    .frag_valid(frag_valid), .frag_ready(frag_ready),
    .frag_x(frag_x), .frag_y(frag_y), .frag_z(frag_z), .frag_color(frag_color),
    .zc_frag_id(zc_frag_id), .zc_rd_en(zc_rd_en), .zc_hit(zc_hit), .zc_zval(zc_zval),
    .zc_upd_id(zc_upd_id), .zc_upd_en(zc_upd_en), .zc_upd_val(zc_upd_val), .zc_upd_hit(zc_upd_hit),
    .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_x(pix_x), .pix_y(pix_y), .pix_color(pix_color),
    .cnt_clr(cnt_clr), .pass_cnt(pass_cnt), .cull_cnt(cull_cnt)
  );

  zbuf_depth_test #(.DEPTH_FUNC(1)) u_leq (
    .clk(clk), .rst(rst),
    .frag_valid(l_frag_valid), .frag_ready(l_frag_ready),
    .frag_x(l_frag_x), .frag_y(l_frag_y), .frag_z(l_frag_z), .frag_color(16'h0A0A),
    .zc_frag_id(l_zc_frag_id), .zc_rd_en(l_zc_rd_en), .zc_hit(1'b1), .zc_zval(16'h2000),
    .zc_upd_id(l_zc_upd_id), .zc_upd_en(l_zc_upd_en), .zc_upd_val(l_zc_upd_val), .zc_upd_hit(1'b1),
    .pix_valid(l_pix_valid), .pix_ready(1'b1),
    .pix_x(l_pix_x), .pix_y(l_pix_y), .pix_color(l_pix_color),
    .cnt_clr(1'b0), .pass_cnt(l_pass_cnt), .cull_cnt(l_cull_cnt)
  );

  // ---------------- reference model state ----------------
  bit          in_flight, m_rd, m_upd, m_pix;
  int          m_cd;
  logic [18:0] m_id;
  logic [9:0]  m_x, m_y;
  logic [15:0] m_z, m_c;
  logic [15:0] exp_pass, exp_cull;
  logic [15:0] zmem [int];
  bit          pre_we = 1'b0;
  logic [18:0] pre_id = '0;
  logic [15:0] pre_val = '0;
  int          miss_cfg = 0, upd_stall_cfg = 0, pix_stall_cfg = 0;

  int n_vec = 0;
  int n_err = 0;

  function automatic logic [18:0] id_of(input int x, input int y);
    int blk;
    blk = ((y / 4) * NXB + (x / 4)) % 32768;
    return 19'(blk * 16 + (y % 4) * 4 + (x % 4));
  endfunction

  function automatic logic [15:0] zmem_rd(input logic [18:0] id);
    int k;
    k = int'(id);
    if (zmem.exists(k)) return zmem[k];
    return 16'hFFFF;
  endfunction

  // Transaction-level model: tracks which handshake the fragment is waiting on.
  initial begin
    in_flight = 0; m_rd = 0; m_upd = 0; m_pix = 0; m_cd = 0;
    m_id = '0; m_x = '0; m_y = '0; m_z = '0; m_c = '0;
    exp_pass = '0; exp_cull = '0;
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        in_flight = 0; m_rd = 0; m_upd = 0; m_pix = 0; m_cd = 0;
        exp_pass = '0; exp_cull = '0;
      end else begin
        if (pre_we) zmem[int'(pre_id)] = pre_val;
        if (!in_flight && frag_valid) begin
          in_flight = 1; m_rd = 1; m_cd = 0;
          m_x = frag_x; m_y = frag_y; m_z = frag_z; m_c = frag_color;
          m_id = id_of(int'(frag_x), int'(frag_y));
        end else if (m_cd > 0) begin
          m_cd--;
          if (m_cd == 1) begin
            m_rd = 0;
          end else if (m_z < zmem_rd(m_id)) begin
            m_upd = 1;
          end else begin
            in_flight = 0;
            exp_cull = exp_cull + 16'd1;
          end
        end else if (m_rd && zc_hit) begin
          m_cd = 2;
        end else if (m_upd && zc_upd_hit) begin
          zmem[int'(m_id)] = m_z;
          exp_pass = exp_pass + 16'd1;
          m_upd = 0; m_pix = 1;
        end else if (m_pix && pix_ready) begin
          m_pix = 0; in_flight = 0;
        end
        if (cnt_clr) begin
          exp_pass = '0; exp_cull = '0;
        end
      end
    end
  end

  // Cache / downstream responder with configurable miss and stall lengths.
  int rd_run = 0, upd_run = 0, pix_run = 0;
  initial begin
    zc_hit = 1'b0; zc_zval = '0; zc_upd_hit = 1'b0; pix_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (zc_rd_en) begin zc_hit = (rd_run >= miss_cfg); rd_run++; end
      else begin zc_hit = 1'b0; rd_run = 0; end
      zc_zval = (m_cd == 2) ? zmem_rd(m_id) : 16'h0000;
      if (zc_upd_en) begin zc_upd_hit = (upd_run >= upd_stall_cfg); upd_run++; end
      else begin zc_upd_hit = 1'b0; upd_run = 0; end
      if (pix_valid) begin pix_ready = (pix_run >= pix_stall_cfg); pix_run++; end
      else begin pix_ready = 1'b0; pix_run = 0; end
    end
  end

  // ---------------- checking helpers (stimulus process only) ----------------
  int          rd_seen = 0, upd_seen = 0, pix_seen = 0, l_upd_seen = 0, l_pix_seen = 0;
  bit          rd_prev = 0;
  logic [18:0] first_id = '0, last_upd_id = '0;
  logic [15:0] last_upd_val = '0, last_pix_color = '0, l_last_upd_val = '0;
  logic [9:0]  last_pix_x = '0, last_pix_y = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    chk("frag_ready", 32'(frag_ready), 32'(!in_flight));
    chk("zc_rd_en", 32'(zc_rd_en), 32'(m_rd));
    chk("zc_upd_en", 32'(zc_upd_en), 32'(m_upd));
    chk("pix_valid", 32'(pix_valid), 32'(m_pix));
    chk("pass_cnt", 32'(pass_cnt), 32'(exp_pass));
    chk("cull_cnt", 32'(cull_cnt), 32'(exp_cull));
    chk("rd_upd_exclusive", 32'(zc_rd_en & zc_upd_en), 32'd0);
    if (m_rd) chk("zc_frag_id", 32'(zc_frag_id), 32'(m_id));
    if (m_upd) begin
      chk("zc_upd_id", 32'(zc_upd_id), 32'(m_id));
      chk("zc_upd_val", 32'(zc_upd_val), 32'(m_z));
    end
    if (m_pix) begin
      chk("pix_x", 32'(pix_x), 32'(m_x));
      chk("pix_y", 32'(pix_y), 32'(m_y));
      chk("pix_color", 32'(pix_color), 32'(m_c));
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (zc_rd_en) begin
      if (!rd_prev) first_id = zc_frag_id;
      rd_seen++;
    end
    rd_prev = zc_rd_en;
    if (zc_upd_en) begin upd_seen++; last_upd_id = zc_upd_id; last_upd_val = zc_upd_val; end
    if (pix_valid) begin
      pix_seen++; last_pix_x = pix_x; last_pix_y = pix_y; last_pix_color = pix_color;
    end
    if (l_zc_upd_en) begin l_upd_seen++; l_last_upd_val = l_zc_upd_val; end
    if (l_pix_valid) l_pix_seen++;
    if (rst) compare_all();
  endtask

  task automatic preload(input logic [18:0] id, input logic [15:0] val);
    pre_id = id; pre_val = val; pre_we = 1'b1;
    tick();
    pre_we = 1'b0;
  endtask

  task automatic send(input int x, input int y, input logic [15:0] z, input logic [15:0] c);
    int accepted;
    accepted = 0;
    frag_x = 10'(x); frag_y = 10'(y); frag_z = z; frag_color = c;
    frag_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (frag_ready) begin
        tick();
        accepted = 1;
        break;
      end
      tick();
    end
    frag_valid = 1'b0;
    chk("accept", 32'(accepted), 32'd1);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 300; i++) begin
      if (!in_flight && frag_ready) break;
      tick();
    end
    chk("done_in_time", 32'(!in_flight && frag_ready), 32'd1);
  endtask

  task automatic l_send(input logic [15:0] z);
    chk("leq_ready", 32'(l_frag_ready), 32'd1);
    l_frag_x = 10'd3; l_frag_y = 10'd3; l_frag_z = z;
    l_frag_valid = 1'b1;
    tick();
    l_frag_valid = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (l_frag_ready) break;
      tick();
    end
    chk("leq_done", 32'(l_frag_ready), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not complete");
    $fatal(1, "watchdog");
  end

  // ---------------- directed stimulus ----------------
  initial begin
    int r0, u0, p0, lu0, lp0;
    tick(); tick();
    chk("rst_frag_ready", 32'(frag_ready), 32'd1);
    chk("rst_rd_en", 32'(zc_rd_en), 32'd0);
    chk("rst_upd_en", 32'(zc_upd_en), 32'd0);
    chk("rst_pix_valid", 32'(pix_valid), 32'd0);
    chk("rst_pass_cnt", 32'(pass_cnt), 32'd0);
    chk("rst_cull_cnt", 32'(cull_cnt), 32'd0);
    chk("rst_frag_id", 32'(zc_frag_id), 32'd0);
    rst = 1'b1;
    tick();

    // pass on immediate hit
    preload(19'd2585, 16'h2000);
    r0 = rd_seen; u0 = upd_seen; p0 = pix_seen;
    send(5, 6, 16'h1000, 16'h1234);
    wait_done();
    chk("t1_first_id", 32'(first_id), 32'({15'd161, 4'b1001}));
    chk("t1_rd_cycles", 32'(rd_seen - r0), 32'd2);
    chk("t1_upd_id", 32'(last_upd_id), 32'd2585);
    chk("t1_upd_val", 32'(last_upd_val), 32'h1000);
    chk("t1_upd_cycles", 32'(upd_seen - u0), 32'd1);
    chk("t1_pix_cycles", 32'(pix_seen - p0), 32'd1);
    chk("t1_pix_x", 32'(last_pix_x), 32'd5);
    chk("t1_pix_y", 32'(last_pix_y), 32'd6);
    chk("t1_pass_cnt", 32'(pass_cnt), 32'd1);

    // greater depth is culled
    preload(19'd2585, 16'h2000);
    u0 = upd_seen; p0 = pix_seen;
    send(5, 6, 16'h3000, 16'h1111);
    wait_done();
    chk("t2_no_upd", 32'(upd_seen - u0), 32'd0);
    chk("t2_no_pix", 32'(pix_seen - p0), 32'd0);
    chk("t2_cull_cnt", 32'(cull_cnt), 32'd1);

    // equal depth is culled under LESS
    u0 = upd_seen;
    send(5, 6, 16'h2000, 16'h2222);
    wait_done();
    chk("t3_no_upd", 32'(upd_seen - u0), 32'd0);
    chk("t3_cull_cnt", 32'(cull_cnt), 32'd2);

    // 20-cycle miss before the hit
    miss_cfg = 20;
    r0 = rd_seen;
    send(100, 37, 16'h0800, 16'h0F0F);
    wait_done();
    miss_cfg = 0;
    chk("t4_first_id", 32'(first_id), 32'd23444);
    chk("t4_rd_cycles", 32'(rd_seen - r0), 32'd22);
    chk("t4_upd_val", 32'(last_upd_val), 32'h0800);
    chk("t4_pass_cnt", 32'(pass_cnt), 32'd2);

    // update stall then 5-cycle downstream stall, far screen corner
    upd_stall_cfg = 3; pix_stall_cfg = 5;
    u0 = upd_seen; p0 = pix_seen;
    send(639, 479, 16'h0001, 16'hBEEF);
    wait_done();
    upd_stall_cfg = 0; pix_stall_cfg = 0;
    chk("t5_first_id", 32'(first_id), 32'd307199);
    chk("t5_upd_cycles", 32'(upd_seen - u0), 32'd4);
    chk("t5_pix_cycles", 32'(pix_seen - p0), 32'd6);
    chk("t5_pix_color", 32'(last_pix_color), 32'hBEEF);
    chk("t5_pix_x", 32'(last_pix_x), 32'd639);
    chk("t5_pass_cnt", 32'(pass_cnt), 32'd3);

    // clear held across the increment cycle: clear wins
    upd_stall_cfg = 2;
    send(8, 8, 16'h0002, 16'h3333);
    for (int i = 0; i < 50; i++) begin
      if (zc_upd_en) break;
      tick();
    end
    cnt_clr = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (!zc_upd_en) break;
      tick();
    end
    cnt_clr = 1'b0;
    upd_stall_cfg = 0;
    wait_done();
    chk("t6_pass_after_clr", 32'(pass_cnt), 32'd0);
    chk("t6_cull_after_clr", 32'(cull_cnt), 32'd0);

    // culled equal-to-far-plane fragment
    send(20, 20, 16'hFFFF, 16'h4444);
    wait_done();
    chk("t7_cull_cnt", 32'(cull_cnt), 32'd1);

    // async reset in the middle of UPDATE
    upd_stall_cfg = 10;
    send(12, 4, 16'h0003, 16'h5555);
    for (int i = 0; i < 50; i++) begin
      if (zc_upd_en) break;
      tick();
    end
    tick(); tick();
    p0 = pix_seen;
    #2 rst = 1'b0;
    #1;
    chk("t8_upd_en", 32'(zc_upd_en), 32'd0);
    chk("t8_pix_valid", 32'(pix_valid), 32'd0);
    chk("t8_frag_ready", 32'(frag_ready), 32'd1);
    chk("t8_rd_en", 32'(zc_rd_en), 32'd0);
    chk("t8_cull_cnt", 32'(cull_cnt), 32'd0);
    chk("t8_pass_cnt", 32'(pass_cnt), 32'd0);
    chk("t8_upd_val", 32'(zc_upd_val), 32'd0);
    chk("t8_pix_x", 32'(pix_x), 32'd0);
    tick();
    rst = 1'b1;
    upd_stall_cfg = 0;
    for (int i = 0; i < 8; i++) tick();
    chk("t8_no_pix", 32'(pix_seen - p0), 32'd0);

    // normal operation after reset
    send(5, 6, 16'h0100, 16'h6666);
    wait_done();
    chk("t9_pass_cnt", 32'(pass_cnt), 32'd1);

    // LEQUAL instance: equal passes, greater culls
    lu0 = l_upd_seen; lp0 = l_pix_seen;
    l_send(16'h2000);
    chk("leq_eq_upd", 32'(l_upd_seen - lu0), 32'd1);
    chk("leq_eq_upd_val", 32'(l_last_upd_val), 32'h2000);
    chk("leq_eq_pix", 32'(l_pix_seen - lp0), 32'd1);
    chk("leq_pass_cnt", 32'(l_pass_cnt), 32'd1);
    chk("leq_cull_cnt0", 32'(l_cull_cnt), 32'd0);
    lu0 = l_upd_seen;
    l_send(16'h2001);
    chk("leq_gt_no_upd", 32'(l_upd_seen - lu0), 32'd0);
    chk("leq_cull_cnt1", 32'(l_cull_cnt), 32'd1);

    tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
